rc4_key_schedule: RTL

Initialises and key-schedules the shared 256-byte RC4 state memory (S) for the decrypt datapath. On a start pulse it fills S[i]=i, then runs the RC4 KSA with a 24-bit secret key: j += S[i] + key[i mod 3], swap S[i], S[j]. It is the writer of S ahead of the PRGA/decrypt engine. It owns the S-memory port only while busy; the top-level arbiter muxes S between this block and the decrypt engine.

---
 rtl/rc4_key_schedule_pkg.sv | 36 +++
 rtl/rc4_key_schedule_if.sv | 25 ++
 rtl/rc4_key_schedule.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rc4_key_schedule_pkg.sv
// Shared RC4 definitions: S-memory geometry, key length, state encoding and key-byte select.
`default_nettype none

package rc4_pkg;

  localparam int S_DEPTH   = 256;
  localparam int KEY_BYTES = 3;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FILL      = 4'd1,
    ST_RD_I_SET  = 4'd2,
    ST_RD_I_WAIT = 4'd3,
    ST_RD_I_GET  = 4'd4,
    ST_CALC_J    = 4'd5,
    ST_RD_J_WAIT = 4'd6,
    ST_RD_J_GET  = 4'd7,
    ST_WR_I      = 4'd8,
    ST_WR_J      = 4'd9,
    ST_INC       = 4'd10,
    ST_DONE      = 4'd11
  } rc4_state_t;

  // Byte 0 is the most significant byte of the key word.
  function automatic logic [7:0] key_byte(input logic [KEY_BYTES*8-1:0] key,
                                          input logic [1:0]             idx);
    case (idx)
      2'd0:    key_byte = key[23:16];
      2'd1:    key_byte = key[15:8];
      default: key_byte = key[7:0];
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/rc4_key_schedule_if.sv
// Start/key handshake and S-memory port between the key scheduler and its host.
`default_nettype none

interface rc4_key_schedule_if;
  logic        start_flag;
  logic [23:0] secret_key;
  logic [7:0]  address;
  logic [7:0]  s_data_in;
  logic [7:0]  s_data_out;
  logic        s_wren;
  logic        busy;
  logic        done_flag;

  modport master (
    output start_flag, secret_key, s_data_out,
    input  address, s_data_in, s_wren, busy, done_flag
  );

  modport slave (
    input  start_flag, secret_key, s_data_out,
    output address, s_data_in, s_wren, busy, done_flag
  );
endinterface

`default_nettype wire

// File: rtl/rc4_key_schedule.sv
// RC4 S-memory fill and key schedule (KSA) with a 24-bit key over a registered-read memory.
// Optional WRITE_VERIFY_EN: hold each write until the memory reads it back.
`default_nettype none

module rc4_key_schedule (
  input  wire logic          clk,
  input  wire logic          reset,
  rc4_key_schedule_if.slave  bus
);
  import rc4_pkg::*;

  rc4_state_t  r_state;
  rc4_state_t  w_next;
  logic [7:0]  r_i;
  logic [7:0]  r_j;
  logic [7:0]  r_si;
  logic [7:0]  r_sj;
  logic [23:0] r_key;
  logic [1:0]  r_kidx;
  logic [7:0]  w_j_new;
  logic [7:0]  w_address;
  logic [7:0]  w_wdata;
  logic        w_wren;
  logic        w_wr_ok;
  logic        w_last_i;

  assign w_j_new  = r_j + r_si + key_byte(r_key, r_kidx);
  assign w_last_i = (r_i == 8'(S_DEPTH - 1));

`ifdef WRITE_VERIFY_EN
  // First cycle of a write only launches it; read-back is meaningful from the next cycle.
  logic r_wr_hold;

  always_ff @(posedge clk) begin
    if (reset)
      r_wr_hold <= 1'b0;
    else
      r_wr_hold <= w_wren && !w_wr_ok;
  end

  assign w_wr_ok = r_wr_hold && (bus.s_data_out == w_wdata);
`else
  assign w_wr_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_address = 8'd0;
    w_wdata   = 8'd0;
    w_wren    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start_flag)
          w_next = ST_FILL;
      end
      ST_FILL: begin
        w_address = r_i;
        w_wdata   = r_i;
        w_wren    = 1'b1;
        if (w_wr_ok && w_last_i)
          w_next = ST_RD_I_SET;
      end
      ST_RD_I_SET: begin
        w_address = r_i;
        w_next    = ST_RD_I_WAIT;
      end
      ST_RD_I_WAIT: begin
        w_address = r_i;
        w_next    = ST_RD_I_GET;
      end
      ST_RD_I_GET: begin
        w_address = r_i;
        w_next    = ST_CALC_J;
      end
      ST_CALC_J: begin
        w_address = w_j_new;
        w_next    = ST_RD_J_WAIT;
      end
      ST_RD_J_WAIT: begin
        w_address = r_j;
        w_next    = ST_RD_J_GET;
      end
      ST_RD_J_GET: begin
        w_address = r_j;
        w_next    = ST_WR_I;
      end
      ST_WR_I: begin
        w_address = r_i;
        w_wdata   = r_sj;
        w_wren    = 1'b1;
        if (w_wr_ok)
          w_next = ST_WR_J;
      end
      ST_WR_J: begin
        w_address = r_j;
        w_wdata   = r_si;
        w_wren    = 1'b1;
        if (w_wr_ok)
          w_next = ST_INC;
      end
      ST_INC: begin
        w_next = w_last_i ? ST_DONE : ST_RD_I_SET;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Datapath registers; the key index is a wrapping counter kept in step with i.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_i    <= 8'd0;
      r_j    <= 8'd0;
      r_si   <= 8'd0;
      r_sj   <= 8'd0;
      r_key  <= 24'd0;
      r_kidx <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_i    <= 8'd0;
          r_j    <= 8'd0;
          r_kidx <= 2'd0;
          if (bus.start_flag)
            r_key <= bus.secret_key;
        end
        ST_FILL: begin
          if (w_wr_ok)
            r_i <= r_i + 8'd1;
        end
        ST_RD_I_GET: r_si <= bus.s_data_out;
        ST_CALC_J:   r_j  <= w_j_new;
        ST_RD_J_GET: r_sj <= bus.s_data_out;
        ST_INC: begin
          if (!w_last_i) begin
            r_i    <= r_i + 8'd1;
            r_kidx <= (r_kidx == 2'(KEY_BYTES - 1)) ? 2'd0 : r_kidx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.address   = w_address;
  assign bus.s_data_in = w_wdata;
  assign bus.s_wren    = w_wren;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done_flag = (r_state == ST_DONE);

endmodule

`default_nettype wire
